fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing one FIFO write port among `NUM_REQ` independent producers. Each producer presents words over a valid/ready handshake. The arbiter picks one winner per cycle, holds the word in a single-entry output stage, and drives the FIFO `wr_en`/`wr_data` pins only when `fifo_full` is low. Per-requester accepted-word counters are readable through a select/value port for board-level debug.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_arb_pick.sv | 51 +++++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the FIFO write arbiter slice.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_CNT_W   = 16;

  localparam int IDX_W = $clog2(DEF_NUM_REQ);

  // Value at which an accepted-word counter stops counting (all ones).
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

  // Advance a requester index by one, wrapping back to zero after n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// priority pointer sits at bit 0, take the lowest set bit, then rotate the
// winning position back into requester numbering.
module rr_arb_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [N-1:0]  rotated;
  logic [IW-1:0] hit;
  logic [IW:0]   sum;

  // Rotate by ptr, scan for the first requester, and undo the rotation.
  always_comb begin
    rotated = '0;
    hit     = '0;
    any     = 1'b0;
    sum     = '0;
    gnt     = '0;
    gnt_idx = '0;

    for (int k = 0; k < N; k++) begin
      rotated[k] = req[IW'((k + int'(ptr)) % N)];
    end

    // Walk downward so the lowest set bit is the one left in hit.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        hit = IW'(k);
        any = 1'b1;
      end
    end

    sum = {1'b0, hit} + {1'b0, ptr};
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    gnt_idx = sum[IW-1:0];

    if (any) begin
      gnt = N'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one FIFO write port from several
// valid/ready producers through a single-entry output stage, with
// saturating per-requester accepted-word counters for debug readback.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_wr_en,
  output logic [DATA_W-1:0]            fifo_wr_data,
  input  logic                         fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  input  logic [$clog2(NUM_REQ)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]             cnt_value
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IW-1:0]     ptr;
  logic [CNT_W-1:0]  count [NUM_REQ];

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               load;
  logic               take;
  logic [DATA_W-1:0]  sel_data;
  logic [IW-1:0]      ptr_next;

  rr_arb_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The FIFO takes the staged word on the same edge whenever it is not full.
  assign fifo_wr_en   = out_valid & ~fifo_full;
  assign fifo_wr_data = out_data;

  // The stage can accept a new word when empty or draining this cycle.
  assign load = ~out_valid | ~fifo_full;

  // Accept the winner only when the stage has room and reset is released.
  always_comb begin
    req_ready = '0;
    if (load && pick_any && !rst) begin
      req_ready = pick_gnt;
    end
  end

  assign take = |req_ready;

  // Select the winning requester's word and the pointer that follows it.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    ptr_next = IW'(wrap_inc(int'(pick_idx), NUM_REQ));
  end

  // Output stage and priority pointer; both freeze while the FIFO backs up.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        grant_id  <= pick_idx;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Count accepted words per requester, sticking at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && count[i] != CNT_MAX) begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end

  // Registered debug readback; selects past the last requester read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_value <= '0;
    end else if (int'(cnt_sel) < NUM_REQ) begin
      cnt_value <= count[cnt_sel];
    end else begin
      cnt_value <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter: expected FIFO writes are
// queued as stimulus is issued and a negedge monitor checks every write.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int CNT_W   = 16;
  localparam int IW      = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_full;
  logic [IW-1:0]             grant_id;
  logic [IW-1:0]             cnt_sel;
  logic [CNT_W-1:0]          cnt_value;

  typedef struct {
    logic [IW-1:0]     id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails  = 0;

  fifo_wr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .cnt_sel      (cnt_sel),
    .cnt_value    (cnt_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                               input logic [NUM_REQ*DATA_W-1:0] data,
                               input logic full);
    req_valid = valid;
    req_data  = data;
    fifo_full = full;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input int id, input logic [DATA_W-1:0] data);
    exp_t e;
    e.id   = IW'(id);
    e.data = data;
    expQ.push_back(e);
  endtask

  // Monitor: every FIFO write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("wr_data", 32'(fifo_wr_data), 32'(e.data));
        checkOutput("wr_grant_id", 32'(grant_id), 32'(e.id));
      end
    end
  end

  // Guard against a stuck run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0t expected < 3000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting fifo_wr_arbiter bench");
    rst     = 1'b1;
    cnt_sel = '0;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    #1;

    // Reset state.
    checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("rst_wr_data", 32'(fifo_wr_data), 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_cnt_value", 32'(cnt_value), 32'h0);

    // All four requesters valid: grants 0,1,2,3,0,1,2,3.
    $display("[TB] all requesters continuously valid");
    applyStimulus(4'b1111, 16'hDCBA, 1'b0);
    checkOutput("rr_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      expectWrite(k % 4, 4'(4'hA + (k % 4)));
    end
    repeat (8) step();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_sel = IW'(i);
      step();
      checkOutput("rr_count", 32'(cnt_value), 32'd2);
    end
    cnt_sel = '0;

    // Only requester 2: words 0xA then 0x5.
    $display("[TB] single requester back-to-back");
    applyStimulus(4'b0100, 16'h0A00, 1'b0);
    checkOutput("single_ready", 32'(req_ready), 32'h4);
    expectWrite(2, 4'hA);
    step();
    applyStimulus(4'b0100, 16'h0500, 1'b0);
    expectWrite(2, 4'h5);
    step();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();

    // Stage holds 0x7 while the FIFO reports full for 5 cycles.
    $display("[TB] backpressure hold");
    applyStimulus(4'b0001, 16'h0007, 1'b0);
    checkOutput("bp_load_ready", 32'(req_ready), 32'h1);
    expectWrite(0, 4'h7);
    step();
    applyStimulus(4'b0010, 16'h0090, 1'b1);
    expectWrite(1, 4'h9);
    checkOutput("bp_ready_held", 32'(req_ready), 32'h0);
    checkOutput("bp_wr_en_held", 32'(fifo_wr_en), 32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp_ready_held", 32'(req_ready), 32'h0);
      checkOutput("bp_wr_en_held", 32'(fifo_wr_en), 32'h0);
    end
    applyStimulus(4'b0010, 16'h0090, 1'b0);
    checkOutput("bp_release_wr_en", 32'(fifo_wr_en), 32'h1);
    checkOutput("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();

    // Pointer wrap: move ptr to 3, then requesters 1 and 3 compete.
    $display("[TB] pointer wrap");
    applyStimulus(4'b0100, 16'h0100, 1'b0);
    checkOutput("wrap_setup_ready", 32'(req_ready), 32'h4);
    expectWrite(2, 4'h1);
    step();
    applyStimulus(4'b1010, 16'h8060, 1'b0);
    checkOutput("wrap_ptr3_ready", 32'(req_ready), 32'h8);
    expectWrite(3, 4'h8);
    step();
    checkOutput("wrap_ptr0_ready", 32'(req_ready), 32'h2);
    expectWrite(1, 4'h6);
    step();
    applyStimulus(4'b1111, 16'h0000, 1'b0);
    checkOutput("wrap_ptr2_ready", 32'(req_ready), 32'h4);
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();

    // Reset while the stage holds a word: the word is discarded.
    $display("[TB] reset mid-operation");
    applyStimulus(4'b0001, 16'h0003, 1'b0);
    checkOutput("rstmid_load_ready", 32'(req_ready), 32'h1);
    step();
    rst = 1'b1;
    applyStimulus(4'b1010, 16'h00E0, 1'b1);
    checkOutput("rstmid_ready_in_reset", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    checkOutput("rstmid_wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("rstmid_grant_id", 32'(grant_id), 32'h0);
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_sel = IW'(i);
      step();
      checkOutput("rstmid_count", 32'(cnt_value), 32'h0);
    end
    cnt_sel = '0;
    applyStimulus(4'b1010, 16'h00E0, 1'b0);
    checkOutput("rstmid_first_grant", 32'(req_ready), 32'h2);
    expectWrite(1, 4'hE);
    step();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    repeat (2) step();

    // Counter saturation on requester 1 (count is 1 here).
    $display("[TB] counter saturation");
    cnt_sel = IW'(1);
    for (int k = 0; k < 65533; k++) begin
      logic [DATA_W-1:0] d;
      d = 4'(k);
      applyStimulus(4'b0010, {8'h00, d, 4'h0}, 1'b0);
      expectWrite(1, d);
      step();
    end
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    step();
    checkOutput("sat_count_near", 32'(cnt_value), 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      logic [DATA_W-1:0] d;
      d = 4'(k + 3);
      applyStimulus(4'b0010, {8'h00, d, 4'h0}, 1'b0);
      expectWrite(1, d);
      step();
    end
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    step();
    checkOutput("sat_count_max", 32'(cnt_value), 32'h0000_FFFF);
    cnt_sel = IW'(0);
    step();
    checkOutput("sat_count_other", 32'(cnt_value), 32'h0);

    repeat (3) step();
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
